// File: rtl/dmux16_32_reg.sv
`default_nettype none
// ============================================================================
// Module      : dmux16_32_reg
// Description : Registered 1-to-6 32-bit demultiplexer with valid/ready
//               handshake, illegal-select drop flag and saturating drop count.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux16_32_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_sel,
    output logic [5:0]  out_valid,
    input  logic [5:0]  out_ready,
    output logic [31:0] out_data,
    output logic        err,
    output logic [7:0]  drop_cnt,
    input  logic        err_clr
);

    localparam logic [2:0] c_LAST_SEL = 3'd5;
    localparam logic [7:0] c_CNT_MAX  = 8'd255;

    logic        r_full;
    logic [2:0]  r_dest;
    logic [31:0] r_data;
    logic [5:0]  r_valid;
    logic        r_err;
    logic [7:0]  r_drop_cnt;

    logic [7:0]  w_ready_ext;
    logic        w_sel_ready;
    logic        w_xfer;
    logic        w_accept;
    logic        w_legal;
    logic        w_load;
    logic        w_drop;

    // r_dest only ever holds 0..5, the padding bits are never addressed
    assign w_ready_ext = {2'b00, out_ready};
    assign w_sel_ready = w_ready_ext[r_dest];
    assign w_xfer      = r_full & w_sel_ready;
    assign in_ready    = ~r_full | w_sel_ready;
    assign w_accept    = in_valid & in_ready;
    assign w_legal     = (in_sel <= c_LAST_SEL);
    assign w_load      = w_accept & w_legal;
    assign w_drop      = w_accept & ~w_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_dest  <= 3'd0;
            r_data  <= 32'h0000_0000;
            r_valid <= 6'b000000;
        end else if (w_load) begin
            r_full  <= 1'b1;
            r_dest  <= in_sel;
            r_data  <= in_data;
            r_valid <= 6'b000001 << in_sel;
        end else if (w_xfer) begin
            // data and destination are kept so out_data shows the last word
            r_full  <= 1'b0;
            r_valid <= 6'b000000;
        end
    end

    // A drop in the same cycle as a clear is counted after the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_drop) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            if (err_clr) begin
                r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
            end else if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign err       = r_err;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmux16_32_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux16_32_reg
// Description : Scoreboard bench for dmux16_32_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux16_32_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_sel;
    logic [5:0]  out_valid;
    logic [5:0]  out_ready;
    logic [31:0] out_data;
    logic        err;
    logic [7:0]  drop_cnt;
    logic        err_clr;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] data;
    } item_t;

    item_t       r_sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_err = 1'b0;
    logic [7:0]  exp_cnt = 8'd0;
    int          waits;

    dmux16_32_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .drop_cnt  (drop_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; model the outcome
    task automatic send(input logic [31:0] d, input logic [2:0] s, output int w);
        item_t it;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (s <= 3'd5) begin
                    it.sel  = s;
                    it.data = d;
                    r_sb.push_back(it);
                end else begin
                    exp_err = 1'b1;
                    if (err_clr)              exp_cnt = 8'd1;
                    else if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
                end
                tick();
                break;
            end
            tick();
            w++;
            if (w > 20) begin
                check("send_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 32'hXXXX_XXXX;
        in_sel   = 3'bxxx;
    endtask

    // Output monitor: compare the offered word, pop on transfer
    always @(negedge clk) begin
        if (!rst && out_valid != 6'b0) begin
            if (r_sb.size() == 0) begin
                check("spurious_valid", {26'd0, out_valid}, 32'd0);
            end else begin
                check("sb_valid", {26'd0, out_valid}, {26'd0, 6'b000001 << r_sb[0].sel});
                check("sb_data", out_data, r_sb[0].data);
                if ((out_valid & out_ready) != 6'b0) void'(r_sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; err_clr = 1'b0; out_ready = 6'b0;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {26'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cnt", {24'd0, drop_cnt}, 32'd0);
        tick();

        // Single route to destination 3
        out_ready = 6'h3f;
        send(32'hDEAD_BEEF, 3'd3, waits);
        idle();
        @(negedge clk);
        check("route_valid", {26'd0, out_valid}, 32'h08);
        check("route_data", out_data, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check("route_drain", {26'd0, out_valid}, 32'd0);
        check("route_hold_data", out_data, 32'hDEAD_BEEF);
        tick();

        // Back-to-back stream across all destinations
        for (int i = 0; i < 6; i++) begin
            send(32'(i + 1), 3'(i), waits);
            check("stream_wait", 32'(waits), 32'd0);
        end
        idle();
        repeat (3) tick();
        check("stream_drained", 32'(r_sb.size()), 32'd0);

        // Backpressure on destination 2 only
        out_ready = 6'b111011;
        send(32'h1234_5678, 3'd2, waits);
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {26'd0, out_valid}, 32'h04);
            check("bp_data", out_data, 32'h1234_5678);
            tick();
        end
        out_ready = 6'b000100;
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {26'd0, out_valid}, 32'h04);
        tick();
        @(negedge clk);
        check("bp_done", {26'd0, out_valid}, 32'd0);
        tick();

        // Illegal selects are dropped and counted
        out_ready = 6'h3f;
        send(32'hBAD0_0006, 3'd6, waits);
        send(32'hBAD0_0007, 3'd7, waits);
        idle();
        @(negedge clk);
        check("ill_valid", {26'd0, out_valid}, 32'd0);
        check("ill_err", {31'd0, err}, 32'd1);
        check("ill_cnt2", {24'd0, drop_cnt}, 32'd2);
        tick();
        for (int i = 0; i < 298; i++) send(32'(i), 3'(6 + (i % 2)), waits);
        idle();
        @(negedge clk);
        check("ill_sat", {24'd0, drop_cnt}, 32'd255);
        check("ill_model", {24'd0, drop_cnt}, {24'd0, exp_cnt});
        tick();

        // Plain clear, then clear colliding with a drop
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_err = 1'b0; exp_cnt = 8'd0;
        @(negedge clk);
        check("clr_err", {31'd0, err}, {31'd0, exp_err});
        check("clr_cnt", {24'd0, drop_cnt}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) send(32'hFFFF_0000, 3'd7, waits);
        idle();
        @(negedge clk);
        check("pre_collide_cnt", {24'd0, drop_cnt}, 32'd5);
        tick();
        err_clr = 1'b1;
        send(32'hFFFF_0001, 3'd6, waits);
        err_clr = 1'b0;
        idle();
        @(negedge clk);
        check("collide_err", {31'd0, err}, {31'd0, exp_err});
        check("collide_cnt", {24'd0, drop_cnt}, {24'd0, exp_cnt});
        check("collide_cnt1", {24'd0, drop_cnt}, 32'd1);
        tick();

        // Reset while a word is held
        out_ready = 6'b0;
        send(32'hCAFE_F00D, 3'd4, waits);
        idle();
        @(negedge clk);
        check("held_valid", {26'd0, out_valid}, 32'h10);
        tick();
        rst = 1'b1;
        r_sb.delete();
        exp_err = 1'b0; exp_cnt = 8'd0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {26'd0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_err", {31'd0, err}, {31'd0, exp_err});
        out_ready = 6'h3f;
        repeat (4) tick();

        check("sb_empty", 32'(r_sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dmux16_32_reg.md
# dmux16_32_reg

Registered 1-to-6 32-bit demultiplexer with valid/ready handshaking. It is the distribution-side counterpart of the 32-bit 6:1 select mux: one upstream producer steers each word to one of six downstream consumers by a 3-bit select code. Codes 0–5 map to outputs 0–5, matching the mux operand order a–f. It sits between the datapath result bus and the six operand/result consumers of the modular-division unit.

## Interface
Parameters:
- none (width fixed at 32, fan-out fixed at 6)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream word present
- in_ready  output  1  block can accept this cycle
- in_data  input  32  word to route
- in_sel  input  3  destination code; 3'b000..3'b101 select outputs 0..5; 3'b110/3'b111 are illegal
- out_valid  output  6  one-hot; bit k set means out_data is offered to destination k
- out_ready  input  6  per-destination accept
- out_data  output  32  shared data bus to all six destinations
- err  output  1  sticky flag: an illegal-select word has been dropped
- drop_cnt  output  8  count of dropped illegal-select words, saturating at 255
- err_clr  input  1  clears err and drop_cnt

## Operation
- Single holding register: full flag, dest_q[2:0], data_q[31:0].
  - out_data = data_q.
  - out_valid = full ? (6'b1 << dest_q) : 6'b0.
- Downstream transfer: full && out_ready[dest_q]. The out_ready bits of non-selected destinations are ignored.
- in_ready = !full || out_ready[dest_q]. This is a combinational pass-through of the selected ready, so a back-to-back stream runs at 1 word/cycle.
- Upstream accept: in_valid && in_ready.
  - Legal in_sel: load data_q ← in_data and dest_q ← in_sel; full ends the cycle at 1.
  - Illegal in_sel (6 or 7): the word is consumed and discarded. The register is not loaded. err ← 1 and drop_cnt ← min(drop_cnt+1, 255).
- Transfer without a legal accept in the same cycle: full ← 0. data_q and dest_q keep their last values, so out_data stays at the last word.
- Transfer and legal accept in the same cycle: the register is reloaded and full stays 1. The destination may change between consecutive words.
- While full and not transferring: data_q and dest_q are held stable. out_valid must not drop or change.
- in_data and in_sel are don't-care when in_valid = 0.
- err_clr:
  - Sets err ← 0 and drop_cnt ← 0.
  - If an illegal word is dropped in the same cycle, the result is err = 1 and drop_cnt = 1 (the drop is counted after the clear).
  - It does not affect the data path.
- Reset values: full = 0, out_valid = 6'b0, out_data = 32'h0000_0000, dest_q = 0, err = 0, drop_cnt = 0.
  - in_ready = 1 during the first cycle after reset release.
  - A reset asserted mid-transfer discards the held word. No out_valid appears for it afterwards.

## Timing
- Latency: a word accepted at edge N is offered (out_valid set) in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while the addressed destination keeps ready high.
- in_ready depends combinationally on out_ready and registered state only. It never depends on in_valid or in_sel.
- All outputs except in_ready come straight from registers.
- An illegal-select drop updates err and drop_cnt at the accept edge. They are visible in the next cycle.
- drop_cnt at 255 stays at 255 on further drops. err stays 1 until err_clr or rst.

## Test plan
- Reset then route: in_data = 32'hDEAD_BEEF, in_sel = 3 with all ready high. Required: out_valid = 6'b001000 and out_data = 32'hDEAD_BEEF one cycle later; full clears after the transfer.
- Streaming across destinations: words 1..6 sent to sel 0..5 on consecutive cycles with all ready high. Required: out_valid walks 000001→100000 on consecutive cycles with matching data; in_ready stays 1 throughout.
- Backpressure: word 32'h1234_5678 to sel 2, out_ready = 6'b111011 for 4 cycles, then 6'b000100. Required: out_valid = 6'b000100 and data stable for 5 cycles; in_ready = 0 for 4 cycles; the transfer occurs on the 5th cycle.
- Illegal select: in_sel = 6 then 7 with valid. Required: no out_valid; err = 1; drop_cnt = 2. After 300 illegal words, drop_cnt = 255.
- err_clr collision: err_clr asserted in the same cycle as an illegal drop, with drop_cnt = 5 beforehand. Required: err = 1, drop_cnt = 1.
- Reset mid-operation: hold a word for sel 4 with out_ready = 0, then assert rst for 1 cycle. Required: out_valid = 0, out_data = 0, in_ready = 1, and the old word never reappears.
